// File: rtl/stepper_pulse_gen.sv
// Multi-channel step/direction pulse generator: each channel issues a programmed
// number of fixed-width step pulses at a latched period, with abort and endstop stops.

module stepper_pulse_gen_ch #(
  parameter int CNT_W   = 32,
  parameter int PULSE_W = 100
) (
  input  logic             clk_clk,
  input  logic             reset_reset_n,
  input  logic [CNT_W-1:0] i_speed,
  input  logic [CNT_W-1:0] i_steps,
  input  logic             i_dir,
  input  logic             i_load,
  input  logic             i_abort,
  input  logic             i_endstop,
  input  logic             i_done_clr,
  output logic             o_step,
  output logic             o_dir,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_halted,
  output logic [CNT_W-1:0] o_remaining
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] ZERO       = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);
  localparam logic [CNT_W-1:0] PULSE_LEN  = CNT_W'(PULSE_W);
  localparam logic [CNT_W-1:0] MIN_PERIOD = CNT_W'(2 * PULSE_W);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_period;
  logic [CNT_W-1:0] r_remaining;
  logic             r_sync1;
  logic             r_sync2;
  logic             r_step;
  logic             r_dir;
  logic             r_busy;
  logic             r_done;
  logic             r_halted;

  logic [CNT_W-1:0] w_period;
  logic             w_accept;
  logic             w_start;
  logic             w_zero_load;
  logic             w_pulse_end;
  logic             w_period_end;
  logic             w_fall;
  logic             w_rise;
  logic             w_halt;
  logic             w_finish;
  logic             w_done_set;

  assign w_period     = (i_speed < MIN_PERIOD) ? MIN_PERIOD : i_speed;
  assign w_accept     = (r_state == IDLE) & i_load & ~i_abort;
  assign w_start      = w_accept & (i_steps != ZERO);
  assign w_zero_load  = w_accept & (i_steps == ZERO);
  assign w_pulse_end  = (r_cnt + ONE) == PULSE_LEN;
  assign w_period_end = r_cnt == (r_period - ONE);
  assign w_done_set   = w_halt | w_finish | w_zero_load;

  // Per-state move events; a synced endstop is only honoured outside a running pulse.
  always_comb begin
    w_fall   = 1'b0;
    w_rise   = 1'b0;
    w_halt   = 1'b0;
    w_finish = 1'b0;
    case (r_state)
      PULSE: begin
        if (i_abort) begin
          w_halt = 1'b1;
        end else if (w_pulse_end) begin
          w_fall = 1'b1;
          w_halt = r_sync2;
        end else begin
          w_halt = 1'b0;
        end
      end
      GAP: begin
        if (i_abort || r_sync2) begin
          w_halt = 1'b1;
        end else if (w_period_end) begin
          if (r_remaining != ZERO) begin
            w_rise = 1'b1;
          end else begin
            w_finish = 1'b1;
          end
        end else begin
          w_halt = 1'b0;
        end
      end
      default: begin
        w_halt = 1'b0;
      end
    endcase
  end

  // Two-flop synchronizer for the asynchronous limit switch.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_endstop;
      r_sync2 <= r_sync1;
    end
  end

  // Channel FSM; a load enters GAP with the counter at period-end so the first rise lands one edge later.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_state     <= IDLE;
      r_cnt       <= ZERO;
      r_period    <= ZERO;
      r_remaining <= ZERO;
      r_step      <= 1'b0;
      r_dir       <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_halted    <= 1'b0;
    end else begin
      if (w_done_set) begin
        r_done <= 1'b1;
      end else if (i_done_clr) begin
        r_done <= 1'b0;
      end else begin
        r_done <= r_done;
      end

      if (w_halt) begin
        r_halted <= 1'b1;
      end else if (w_start || i_done_clr) begin
        r_halted <= 1'b0;
      end else begin
        r_halted <= r_halted;
      end

      if (w_halt || w_finish) begin
        r_state <= IDLE;
        r_step  <= 1'b0;
        r_busy  <= 1'b0;
        r_cnt   <= ZERO;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_start) begin
              r_state     <= GAP;
              r_busy      <= 1'b1;
              r_period    <= w_period;
              r_cnt       <= w_period - ONE;
              r_dir       <= i_dir;
              r_remaining <= i_steps;
            end else begin
              r_state <= IDLE;
            end
          end
          PULSE: begin
            r_cnt <= r_cnt + ONE;
            if (w_fall) begin
              r_step  <= 1'b0;
              r_state <= GAP;
            end else begin
              r_state <= PULSE;
            end
          end
          GAP: begin
            if (w_rise) begin
              r_step      <= 1'b1;
              r_remaining <= r_remaining - ONE;
              r_cnt       <= ZERO;
              r_state     <= PULSE;
            end else begin
              r_cnt <= r_cnt + ONE;
            end
          end
          default: begin
            r_state <= IDLE;
            r_step  <= 1'b0;
            r_busy  <= 1'b0;
            r_cnt   <= ZERO;
          end
        endcase
      end
    end
  end

  assign o_step      = r_step;
  assign o_dir       = r_dir;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_halted    = r_halted;
  assign o_remaining = r_remaining;

endmodule

module stepper_pulse_gen #(
  parameter int NUM_CH  = 5,
  parameter int CNT_W   = 32,
  parameter int PULSE_W = 100
) (
  input  logic                    clk_clk,
  input  logic                    reset_reset_n,
  input  logic [NUM_CH*CNT_W-1:0] speed_i,
  input  logic [NUM_CH*CNT_W-1:0] steps_i,
  input  logic [NUM_CH-1:0]       dir_i,
  input  logic [NUM_CH-1:0]       load_i,
  input  logic [NUM_CH-1:0]       abort_i,
  input  logic [NUM_CH-1:0]       endstop_i,
  input  logic [NUM_CH-1:0]       done_clr_i,
  output logic [NUM_CH-1:0]       step_o,
  output logic [NUM_CH-1:0]       dir_o,
  output logic [NUM_CH-1:0]       busy_o,
  output logic [NUM_CH-1:0]       done_o,
  output logic [NUM_CH-1:0]       halted_o,
  output logic [NUM_CH*CNT_W-1:0] remaining_o
);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    stepper_pulse_gen_ch #(
      .CNT_W   (CNT_W),
      .PULSE_W (PULSE_W)
    ) u_ch (
      .clk_clk       (clk_clk),
      .reset_reset_n (reset_reset_n),
      .i_speed       (speed_i[c*CNT_W +: CNT_W]),
      .i_steps       (steps_i[c*CNT_W +: CNT_W]),
      .i_dir         (dir_i[c]),
      .i_load        (load_i[c]),
      .i_abort       (abort_i[c]),
      .i_endstop     (endstop_i[c]),
      .i_done_clr    (done_clr_i[c]),
      .o_step        (step_o[c]),
      .o_dir         (dir_o[c]),
      .o_busy        (busy_o[c]),
      .o_done        (done_o[c]),
      .o_halted      (halted_o[c]),
      .o_remaining   (remaining_o[c*CNT_W +: CNT_W])
    );
  end

endmodule
